// File: rtl/axi_write_arbiter_if.sv
//==================================================================
// Module : axi_write_arbiter_if
// Desc   : Write-channel bundle between two burst writers (packed
//          2-port s_axi_* side) and one AXI3 HP write port (m_axi_*).
//          The master modport is the arbiter's view; slave is the
//          surrounding environment's view.
// Rev    : 1.0  initial release
//==================================================================
`default_nettype none

interface axi_write_arbiter_if #(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64
) ();

  // writer side, port i lives at slice i of every packed vector
  logic [2*AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [2*4-1:0]              s_axi_awlen;
  logic [1:0]                  s_axi_awvalid;
  logic [1:0]                  s_axi_awready;
  logic [2*AXI_DATA_WIDTH-1:0] s_axi_wdata;
  logic [1:0]                  s_axi_wlast;
  logic [1:0]                  s_axi_wvalid;
  logic [1:0]                  s_axi_wready;
  logic [1:0]                  s_axi_bvalid;
  logic [1:0]                  s_axi_bready;

  // HP slave port side
  logic [AXI_ID_WIDTH-1:0]     m_axi_awid;
  logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [3:0]                  m_axi_awlen;
  logic                        m_axi_awvalid;
  logic                        m_axi_awready;
  logic [AXI_ID_WIDTH-1:0]     m_axi_wid;
  logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata;
  logic                        m_axi_wlast;
  logic                        m_axi_wvalid;
  logic                        m_axi_wready;
  logic [AXI_ID_WIDTH-1:0]     m_axi_bid;
  logic                        m_axi_bvalid;
  logic                        m_axi_bready;

  modport master (
    input  s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    input  s_axi_wdata, s_axi_wlast, s_axi_wvalid, s_axi_bready,
    input  m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bvalid,
    output s_axi_awready, s_axi_wready, s_axi_bvalid,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
    output m_axi_wid, m_axi_wdata, m_axi_wlast, m_axi_wvalid,
    output m_axi_bready
  );

  modport slave (
    output s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    output s_axi_wdata, s_axi_wlast, s_axi_wvalid, s_axi_bready,
    output m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bvalid,
    input  s_axi_awready, s_axi_wready, s_axi_bvalid,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
    input  m_axi_wid, m_axi_wdata, m_axi_wlast, m_axi_wvalid,
    input  m_axi_bready
  );

endinterface

`default_nettype wire

// File: rtl/axi_write_arbiter.sv
//==================================================================
// Module : axi_write_arbiter
// Desc   : Shares one AXI3 HP write port between two burst writers.
//          AW is arbitrated round-robin and re-issued through a
//          register stage; W beats follow AW grant order via a small
//          order FIFO; B responses are steered back by bid[0].
// Rev    : 1.0  initial release
//==================================================================
`default_nettype none

module axi_write_arbiter #(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int ORDER_DEPTH    = 4
) (
  input  logic                           aclk,
  input  logic                           areset,
  axi_write_arbiter_if.master            bus,
  output logic [$clog2(ORDER_DEPTH):0]   sts_pending
);

  localparam int PTR_W = $clog2(ORDER_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(ORDER_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic             last_grant;   // port that won the previous AW
  logic             prio;         // port preferred in this arbitration
  logic             winner;
  logic             grant_valid;  // AW accepted from a writer this cycle
  logic             aw_push;      // AW accepted by the HP port this cycle

  logic [ORDER_DEPTH-1:0] order_mem;  // one port-index bit per entry
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   head;
  logic                   w_pop;
  logic                   bid_unused;

  assign prio       = ~last_grant;
  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign head       = order_mem[rd_ptr];

  // AW state register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // AW next-state and writer-side ready; the non-preferred port wins only
  // when the preferred one is idle
  always_comb begin
    state_nxt          = state;
    grant_valid        = 1'b0;
    aw_push            = 1'b0;
    bus.s_axi_awready  = 2'b00;
    winner             = bus.s_axi_awvalid[prio] ? prio : last_grant;
    case (state)
      ST_IDLE: begin
        if (!areset && !fifo_full && (bus.s_axi_awvalid != 2'b00)) begin
          grant_valid               = 1'b1;
          bus.s_axi_awready[winner] = 1'b1;
          state_nxt                 = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.m_axi_awready) begin
          aw_push   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // AW register stage toward the HP port and round-robin pointer
  always_ff @(posedge aclk) begin
    if (areset) begin
      bus.m_axi_awvalid <= 1'b0;
      bus.m_axi_awaddr  <= '0;
      bus.m_axi_awlen   <= '0;
      bus.m_axi_awid    <= '0;
      last_grant        <= 1'b1;  // makes port 0 the first preferred port
    end else if (grant_valid) begin
      bus.m_axi_awvalid <= 1'b1;
      bus.m_axi_awaddr  <= winner ? bus.s_axi_awaddr[AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]
                                  : bus.s_axi_awaddr[0 +: AXI_ADDR_WIDTH];
      bus.m_axi_awlen   <= winner ? bus.s_axi_awlen[4 +: 4] : bus.s_axi_awlen[0 +: 4];
      bus.m_axi_awid    <= {{(AXI_ID_WIDTH-1){1'b0}}, winner};
    end else if (aw_push) begin
      bus.m_axi_awvalid <= 1'b0;
      last_grant        <= bus.m_axi_awid[0];
    end
  end

  // grant-order FIFO: pushed on HP AW handshake, popped on the last W beat
  always_ff @(posedge aclk) begin
    if (areset) begin
      order_mem <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (aw_push) begin
        order_mem[wr_ptr] <= bus.m_axi_awid[0];
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (w_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({aw_push, w_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // W routing from the FIFO head; nothing passes while the FIFO is empty
  always_comb begin
    bus.m_axi_wvalid = 1'b0;
    bus.s_axi_wready = 2'b00;
    bus.m_axi_wdata  = head ? bus.s_axi_wdata[AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
                            : bus.s_axi_wdata[0 +: AXI_DATA_WIDTH];
    bus.m_axi_wlast  = bus.s_axi_wlast[head];
    if (!fifo_empty) begin
      bus.m_axi_wvalid       = bus.s_axi_wvalid[head];
      bus.s_axi_wready[head] = bus.m_axi_wready;
    end
  end

  assign bus.m_axi_wid = {{(AXI_ID_WIDTH-1){1'b0}}, head};
  assign w_pop         = bus.m_axi_wvalid & bus.m_axi_wready & bus.m_axi_wlast;
  assign sts_pending   = count;

  // B steering: bid[0] names the source port, upper ID bits are ignored
  assign bus.s_axi_bvalid = {bus.m_axi_bvalid & bus.m_axi_bid[0],
                             bus.m_axi_bvalid & ~bus.m_axi_bid[0]};
  assign bus.m_axi_bready = bus.s_axi_bready[bus.m_axi_bid[0]];
  assign bid_unused       = ^bus.m_axi_bid[AXI_ID_WIDTH-1:1];

endmodule

`default_nettype wire

// File: tb/tb_axi_write_arbiter.sv
//==================================================================
// Module : tb_axi_write_arbiter
// Desc   : Bench for axi_write_arbiter: directed scenarios with literal
//          expectations plus randomized writers, all checked every
//          cycle against a queue-based behavioural model.
// Rev    : 1.0  initial release
//==================================================================
`default_nettype none

module tb_axi_write_arbiter;

  localparam int IDW   = 6;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic clk;
  logic areset;
  logic [$clog2(DEPTH):0] sts_pending;

  axi_write_arbiter_if #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

  axi_write_arbiter #(
    .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .ORDER_DEPTH(DEPTH)
  ) dut (
    .aclk(clk), .areset(areset), .bus(bus), .sts_pending(sts_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Order of granted ports is a queue; the AW register stage is "one
  // pending request or none"; arbitration prefers the port that did not
  // win last time.
  bit              m_busy = 1'b0;
  logic [AW-1:0]   m_addr = '0;
  logic [3:0]      m_len  = '0;
  int              m_id   = 0;
  int              m_last = 1;
  int              oq[$];
  logic [1:0]      hs_aw = 2'b00;
  logic [1:0]      hs_w  = 2'b00;

  // per-cycle comparison against the model, then advance the model
  always @(negedge clk) begin
    logic [1:0] e_awready, e_wready, e_bvalid;
    int  h, pri, win, bi;
    bit  nonempty, gv, pop;
    nonempty = (oq.size() != 0);
    h        = nonempty ? oq[0] : 0;

    e_awready = 2'b00;
    gv        = 1'b0;
    pri       = 1 - m_last;
    win       = bus.s_axi_awvalid[pri] ? pri : m_last;
    if (!areset && !m_busy && oq.size() < DEPTH && bus.s_axi_awvalid != 2'b00) begin
      gv             = 1'b1;
      e_awready[win] = 1'b1;
    end
    chk("s_axi_awready", bus.s_axi_awready, e_awready);
    chk("m_axi_awvalid", bus.m_axi_awvalid, m_busy);
    chk("m_axi_awaddr",  bus.m_axi_awaddr, m_addr);
    chk("m_axi_awlen",   bus.m_axi_awlen, m_len);
    chk("m_axi_awid",    bus.m_axi_awid, m_id);

    e_wready = 2'b00;
    if (nonempty) e_wready[h] = bus.m_axi_wready;
    chk("m_axi_wvalid", bus.m_axi_wvalid, nonempty ? bus.s_axi_wvalid[h] : 1'b0);
    chk("s_axi_wready", bus.s_axi_wready, e_wready);
    if (nonempty) begin
      chk("m_axi_wid",   bus.m_axi_wid, h);
      chk("m_axi_wdata", bus.m_axi_wdata, bus.s_axi_wdata[h*DW +: DW]);
      chk("m_axi_wlast", bus.m_axi_wlast, bus.s_axi_wlast[h]);
    end

    bi = int'(bus.m_axi_bid[0]);
    e_bvalid = 2'b00;
    e_bvalid[bi] = bus.m_axi_bvalid;
    chk("s_axi_bvalid", bus.s_axi_bvalid, e_bvalid);
    chk("m_axi_bready", bus.m_axi_bready, bus.s_axi_bready[bi]);
    chk("sts_pending",  sts_pending, oq.size());

    hs_aw = bus.s_axi_awvalid & bus.s_axi_awready;
    hs_w  = bus.s_axi_wvalid  & bus.s_axi_wready;

    if (areset) begin
      m_busy = 1'b0; m_addr = '0; m_len = '0; m_id = 0; m_last = 1;
      oq.delete();
    end else begin
      pop = nonempty && bus.s_axi_wvalid[h] && bus.m_axi_wready && bus.s_axi_wlast[h];
      if (pop) void'(oq.pop_front());
      if (m_busy && bus.m_axi_awready) begin
        m_busy = 1'b0;
        oq.push_back(m_id);
        m_last = m_id;
      end else if (gv) begin
        m_busy = 1'b1;
        m_addr = bus.s_axi_awaddr[win*AW +: AW];
        m_len  = bus.s_axi_awlen[win*4 +: 4];
        m_id   = win;
      end
    end
  end

  // ---------------- stimulus ----------------
  int ids[4];
  int n_ids;
  int wq[2][$];
  int beat[2];
  int cur_len[2];

  initial begin
    areset = 1'b1;
    bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awvalid = '0;
    bus.s_axi_wdata = '0;  bus.s_axi_wlast = '0; bus.s_axi_wvalid = '0;
    bus.s_axi_bready = '0; bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_bid = '0;    bus.m_axi_bvalid = 1'b0;
    repeat (3) tick();

    // reset state
    @(negedge clk);
    chk("rst awvalid", bus.m_axi_awvalid, 0);
    chk("rst awaddr",  bus.m_axi_awaddr, 0);
    chk("rst awid",    bus.m_axi_awid, 0);
    chk("rst wvalid",  bus.m_axi_wvalid, 0);
    chk("rst pending", sts_pending, 0);
    tick();
    areset = 1'b0;

    // B steering by bid[0]
    bus.m_axi_bvalid = 1'b1; bus.m_axi_bid = 6'h01; bus.s_axi_bready = 2'b01;
    @(negedge clk);
    chk("b bvalid id1", bus.s_axi_bvalid, 2'b10);
    chk("b bready id1 held", bus.m_axi_bready, 0);
    tick();
    bus.s_axi_bready = 2'b10;
    @(negedge clk);
    chk("b bready id1", bus.m_axi_bready, 1);
    tick();
    bus.m_axi_bid = 6'h3E;
    @(negedge clk);
    chk("b bvalid id0", bus.s_axi_bvalid, 2'b01);
    chk("b bready id0 held", bus.m_axi_bready, 0);
    tick();
    bus.m_axi_bvalid = 1'b0; bus.s_axi_bready = 2'b00; bus.m_axi_bid = '0;

    // single 16-beat burst from port 0
    bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
    bus.s_axi_awaddr[0 +: AW] = 32'h1000; bus.s_axi_awlen[0 +: 4] = 4'd15;
    bus.s_axi_awvalid = 2'b01;
    @(negedge clk);
    chk("t1 awready", bus.s_axi_awready, 2'b01);
    chk("t1 awvalid pre", bus.m_axi_awvalid, 0);
    tick();
    bus.s_axi_awvalid = 2'b00;
    @(negedge clk);
    chk("t1 awvalid", bus.m_axi_awvalid, 1);
    chk("t1 awaddr", bus.m_axi_awaddr, 32'h1000);
    chk("t1 awlen", bus.m_axi_awlen, 15);
    chk("t1 awid", bus.m_axi_awid, 0);
    chk("t1 awready busy", bus.s_axi_awready, 2'b00);
    tick();
    @(negedge clk);
    chk("t1 pending", sts_pending, 1);
    for (int b = 0; b < 16; b++) begin
      bus.s_axi_wdata[0 +: DW] = 64'hA00 + 64'(b);
      bus.s_axi_wlast[0] = (b == 15);
      bus.s_axi_wvalid[0] = 1'b1;
      @(negedge clk);
      chk("t1 wdata", bus.m_axi_wdata, 64'hA00 + 64'(b));
      chk("t1 wready", bus.s_axi_wready, 2'b01);
      chk("t1 beat pending", sts_pending, 1);
      tick();
    end
    bus.s_axi_wvalid = 2'b00; bus.s_axi_wlast = 2'b00;
    @(negedge clk);
    chk("t1 popped", sts_pending, 0);

    // both ports streaming single-beat AWs with W stalled: alternation and FIFO full
    bus.s_axi_awaddr = {32'h3000, 32'h2000}; bus.s_axi_awlen = 8'h00;
    bus.s_axi_awvalid = 2'b11; bus.m_axi_wready = 1'b0;
    n_ids = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        if (n_ids < 4) ids[n_ids] = int'(bus.m_axi_awid);
        n_ids++;
      end
      tick();
    end
    chk("t2 aw count", n_ids, 4);
    chk("t2 id0", ids[0], 1);
    chk("t2 id1", ids[1], 0);
    chk("t2 id2", ids[2], 1);
    chk("t2 id3", ids[3], 0);
    @(negedge clk);
    chk("t4 full pending", sts_pending, 4);
    chk("t4 full awready", bus.s_axi_awready, 2'b00);
    tick();
    bus.s_axi_wdata = {64'hD1, 64'hD0}; bus.s_axi_wlast = 2'b11;
    bus.s_axi_wvalid = 2'b11; bus.m_axi_wready = 1'b1;
    @(negedge clk);
    chk("t4 still blocked", bus.s_axi_awready, 2'b00);
    chk("t2 head data", bus.m_axi_wdata, 64'hD1);
    chk("t2 head wready", bus.s_axi_wready, 2'b10);
    tick();
    @(negedge clk);
    chk("t4 grant after pop", bus.s_axi_awready, 2'b10);
    chk("t2 second data", bus.m_axi_wdata, 64'hD0);
    tick();
    bus.s_axi_awvalid = 2'b00;
    repeat (6) tick();
    bus.s_axi_wvalid = 2'b00; bus.s_axi_wlast = 2'b00;
    @(negedge clk);
    chk("t2 drained", sts_pending, 0);
    tick();

    // HP port stalls AW: only one accepted, then the other port
    bus.m_axi_awready = 1'b0; bus.s_axi_awvalid = 2'b11;
    @(negedge clk);
    chk("t3 first grant", bus.s_axi_awready, 2'b01);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3 stall awready", bus.s_axi_awready, 2'b00);
      chk("t3 stall awvalid", bus.m_axi_awvalid, 1);
      tick();
    end
    bus.m_axi_awready = 1'b1;
    @(negedge clk);
    chk("t3 release busy", bus.s_axi_awready, 2'b00);
    tick();
    @(negedge clk);
    chk("t3 other port", bus.s_axi_awready, 2'b10);
    tick();
    bus.s_axi_awvalid = 2'b00;
    tick();
    bus.s_axi_wlast = 2'b11; bus.s_axi_wvalid = 2'b11;
    repeat (4) tick();
    bus.s_axi_wvalid = 2'b00; bus.s_axi_wlast = 2'b00;
    @(negedge clk);
    chk("t3 drained", sts_pending, 0);
    tick();

    // reset mid-burst at beat 7
    bus.s_axi_awaddr[0 +: AW] = 32'h4000; bus.s_axi_awlen[0 +: 4] = 4'd15;
    bus.s_axi_awvalid = 2'b01;
    tick();
    bus.s_axi_awvalid = 2'b00;
    tick();
    for (int b = 0; b < 7; b++) begin
      bus.s_axi_wvalid[0] = 1'b1; bus.s_axi_wdata[0 +: DW] = 64'(b);
      tick();
    end
    areset = 1'b1;
    tick();
    areset = 1'b0;
    bus.s_axi_awlen = 8'h00; bus.s_axi_awvalid = 2'b11;
    @(negedge clk);
    chk("t6 awvalid", bus.m_axi_awvalid, 0);
    chk("t6 wvalid", bus.m_axi_wvalid, 0);
    chk("t6 wready", bus.s_axi_wready, 2'b00);
    chk("t6 pending", sts_pending, 0);
    chk("t6 port0 first", bus.s_axi_awready, 2'b01);
    tick();
    areset = 1'b1; bus.s_axi_awvalid = 2'b00; bus.s_axi_wvalid = 2'b00;
    tick();
    areset = 1'b0;
    tick();

    // randomized writers and HP port behaviour
    for (int i = 0; i < 2; i++) begin
      wq[i].delete(); beat[i] = 0; cur_len[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (cyc > 0 && hs_aw[i]) begin
          bus.s_axi_awvalid[i] = 1'b0;
          wq[i].push_back(cur_len[i]);
        end
        if (cyc > 0 && hs_w[i]) begin
          if (bus.s_axi_wlast[i]) begin
            void'(wq[i].pop_front());
            beat[i] = 0;
          end else begin
            beat[i]++;
          end
          bus.s_axi_wvalid[i] = 1'b0;
        end
        if (!bus.s_axi_awvalid[i] && $urandom_range(0, 3) == 0) begin
          cur_len[i] = $urandom_range(0, 15);
          bus.s_axi_awaddr[i*AW +: AW] = {$urandom_range(0, 65535), 16'h0} | (i << 12);
          bus.s_axi_awlen[i*4 +: 4] = 4'(cur_len[i]);
          bus.s_axi_awvalid[i] = 1'b1;
        end
        if (!bus.s_axi_wvalid[i] && wq[i].size() != 0 && $urandom_range(0, 3) != 0) begin
          bus.s_axi_wdata[i*DW +: DW] = {$urandom, $urandom};
          bus.s_axi_wlast[i] = (beat[i] == wq[i][0]);
          bus.s_axi_wvalid[i] = 1'b1;
        end
      end
      bus.m_axi_awready = ($urandom_range(0, 3) != 0);
      bus.m_axi_wready  = ($urandom_range(0, 3) != 0);
      bus.m_axi_bvalid  = ($urandom_range(0, 1) != 0);
      bus.m_axi_bid     = 6'($urandom);
      bus.s_axi_bready  = 2'($urandom);
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_write_arbiter.md
Name: axi_write_arbiter

Overview:
Shares one AXI3 HP write port between two burst writers, e.g. two ram writer instances issuing 16-beat INCR bursts.
- AW requests are arbitrated round-robin and re-issued on the master port through a register stage.
- W beats are routed strictly in AW grant order through an order FIFO.
- B responses are routed back by the ID bit that encodes the source port.
- Sits between the writer cores and the PS HP slave port.

Parameters:
AXI_ID_WIDTH, 6, width of m_axi_awid/m_axi_wid/m_axi_bid; LSB carries source port index.
AXI_ADDR_WIDTH, 32, address width.
AXI_DATA_WIDTH, 64, write data width.
ORDER_DEPTH, 4, entries in the grant-order FIFO (power of 2, >=2).

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
s_axi_awaddr  in  2*AXI_ADDR_WIDTH  port i at bits [i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]
s_axi_awlen  in  2*4  burst lengths, packed the same way
s_axi_awvalid  in  2  per-port AW valid
s_axi_awready  out  2  per-port AW ready
s_axi_wdata  in  2*AXI_DATA_WIDTH  per-port write data
s_axi_wlast  in  2  per-port wlast
s_axi_wvalid  in  2  per-port W valid
s_axi_wready  out  2  per-port W ready
s_axi_bvalid  out  2  per-port B valid
s_axi_bready  in  2  per-port B ready
m_axi_awid  out  AXI_ID_WIDTH  {zeros, granted port index}
m_axi_awaddr  out  AXI_ADDR_WIDTH  registered address
m_axi_awlen  out  4  registered burst length
m_axi_awvalid  out  1  AW valid
m_axi_awready  in  1  AW ready
m_axi_wid  out  AXI_ID_WIDTH  {zeros, order-FIFO head}
m_axi_wdata  out  AXI_DATA_WIDTH  muxed data
m_axi_wlast  out  1  muxed wlast
m_axi_wvalid  out  1  W valid
m_axi_wready  in  1  W ready
m_axi_bid  in  AXI_ID_WIDTH  response ID
m_axi_bvalid  in  1  B valid
m_axi_bready  out  1  B ready
sts_pending  out  $clog2(ORDER_DEPTH)+1  order-FIFO occupancy

Behaviour:
Reset: all of the following are 0 (sts_pending 0 means the FIFO is empty):
- m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awid
- s_axi_awready, s_axi_wready, s_axi_bvalid
- m_axi_wvalid, m_axi_bready
- sts_pending; RR pointer = port 0 has priority.

Reset mid-burst drops all state. Writers must be reset in the same cycle.

AW FSM, two states:
- IDLE: if FIFO not full and any s_axi_awvalid, pick the winner.
  - Priority port = ~last_grant. The other port wins only if the priority port is not requesting.
  - s_axi_awready[winner]=1 combinationally in this cycle only.
  - Latch awaddr/awlen/index; next cycle m_axi_awvalid=1, state BUSY.
- BUSY: s_axi_awready=0. On m_axi_awready:
  - m_axi_awvalid<=0;
  - push index into the order FIFO;
  - last_grant<=index;
  - state IDLE.
- Throughput: one AW per 2 cycles minimum when m_axi_awready is held high.
- FIFO full (sts_pending==ORDER_DEPTH): IDLE grants nothing until a pop.

W path (combinational, no added latency):
- With FIFO non-empty and head h:
  - m_axi_wvalid = s_axi_wvalid[h];
  - s_axi_wready[h] = m_axi_wready; other port's wready = 0;
  - wdata/wlast muxed from h.
- FIFO empty: m_axi_wvalid=0, both wready=0. W beats never precede their AW on the master port.
- Pop on m_axi_wvalid & m_axi_wready & wlast.
- Push and pop in the same cycle leave sts_pending unchanged. A push into a full FIFO is impossible by construction.

B path (combinational):
- s_axi_bvalid[i] = m_axi_bvalid & (m_axi_bid[0]==i).
- m_axi_bready = s_axi_bready[m_axi_bid[0]].

Arithmetic and widths:
- FIFO pointers wrap modulo ORDER_DEPTH.
- ID upper bits are always 0; awlen passes through unchanged.

Test Plan:
1. Only port 0 requests addr 0x1000, len 15 → awready[0] at cycle t; m_axi_awvalid at t+1 with addr 0x1000, awid 0; 16 beats pass; FIFO pops on the 16th beat.
2. Both ports hold awvalid continuously, awready=1 → grant sequence 0,1,0,1…; awid alternates; W data ordered to match.
3. m_axi_awready held 0 → at most one AW accepted; other port's awready stays 0. Release → next grant goes to the other port.
4. ORDER_DEPTH=4, wready=0, 5 bursts requested → 4 AWs issued; sts_pending=4; 5th awready stays 0 until the first wlast handshake.
5. bvalid with bid=1 → s_axi_bvalid=2'b10; s_axi_bready[1]=0 holds m_axi_bready=0.
6. Assert areset mid-burst (beat 7) → next cycle all valids/readys 0, sts_pending=0, next grant goes to port 0.
